// File: rtl/bin2bcd_seq_if.sv
// Start/done bus between a requester and the bin2bcd_seq converter.
// Optional blank output exists only when BIN2BCD_BLANK_EN is defined.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 9
);
    // start is taken only while busy=0; bin is captured on that edge.
    // done pulses one cycle when bcd/overflow (and blank) have just updated.
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;
`endif

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
`ifdef BIN2BCD_BLANK_EN
        input  blank,
`endif
        input  overflow
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
`ifdef BIN2BCD_BLANK_EN
        output blank,
`endif
        output overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one add-3/shift step per clock.
// Define BIN2BCD_BLANK_EN to add the leading-zero blank output on the bus.
module bin2bcd_seq #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 9
) (
    input  logic              clk,
    input  logic              rst,
    bin2bcd_seq_if.slave      bus,
    output logic [1:0]        o_state
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept;
    logic                w_last;

    logic [BIN_W-1:0]    r_bin;
    logic [BCD_W-1:0]    r_work;
    logic                r_sticky;
    logic [CNT_W-1:0]    r_cnt;
    logic [BCD_W-1:0]    r_bcd;
    logic                r_ovf;

    logic [BCD_W-1:0]    w_adj;
    logic [BCD_W-1:0]    w_work_next;
    logic [BIN_W-1:0]    w_bin_next;
    logic                w_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == CNT_W'(BIN_W - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CONV;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Per-digit add-3 is 4-bit wide; no carry crosses digit boundaries.
    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_work[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_carry     = w_adj[BCD_W-1];
    assign w_work_next = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
    assign w_bin_next  = {r_bin[BIN_W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin    <= '0;
            r_work   <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
            r_bcd    <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_bin    <= bus.bin;
            r_work   <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == S_CONV) begin
            r_bin    <= w_bin_next;
            r_work   <= w_work_next;
            r_sticky <= r_sticky | w_carry;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_bcd <= w_work_next;
                r_ovf <= r_sticky | w_carry;
            end
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]   r_blank;
    logic [DIGITS-1:0]   w_blank_next;

    // A digit blanks only if it and every more significant digit are zero.
    always_comb begin
        logic all_zero;
        all_zero     = 1'b1;
        w_blank_next = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero        = all_zero & (w_work_next[4*i +: 4] == 4'd0);
            w_blank_next[i] = all_zero;
        end
        w_blank_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blank <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else if (w_last) begin
            r_blank <= w_blank_next;
        end
    end

    assign bus.blank = r_blank;
`endif

    assign bus.busy     = (r_state == S_CONV);
    assign bus.done     = (r_state == S_DONE);
    assign bus.bcd      = r_bcd;
    assign bus.overflow = r_ovf;
    assign o_state      = r_state;
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative double-dabble: one add-3/shift step per clock.
- Inverse of the team's combinational BCD-to-binary path. Turns test results and operands (up to 9 decimal digits) back into packed BCD for the 7-segment/display front end.
- Start/done handshake; result held stable until the next conversion completes.

Parameters:
- BIN_W, 32: width of binary input; also the number of conversion steps.
- DIGITS, 9: number of BCD digits produced; bcd width is 4*DIGITS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; sampled only when busy=0.
- bin  in  BIN_W  binary operand; captured on the accepted-start edge, may change afterwards.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse: bcd/overflow just updated.
- bcd  out  4*DIGITS  packed BCD result; digit i at [4i+3:4i], digit 0 = units.
- overflow  out  1  high if the operand exceeds 10^DIGITS-1; valid with bcd.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, bcd=0, overflow=0, step counter=0, internal shift registers=0.
- Reset mid-conversion: the result is abandoned, outputs return to reset values on that edge, and no done pulse is issued.
- States:
  - IDLE: busy=0, done=0.
  - CONV: busy=1.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Transitions:
  - IDLE and start=1 -> CONV. Load the bin register with bin, clear the BCD work register, clear the overflow-sticky flag, set counter=0.
  - CONV, each cycle:
    - Add 3 to every work digit >=5.
    - Shift {work,binreg} left by 1.
    - If the bit shifted out of the top digit is 1, set overflow-sticky.
    - counter++.
    - On the step where counter reaches BIN_W-1: load bcd with the shifted work value, load overflow with the final sticky value, go to DONE.
  - DONE and start=1 -> CONV, loading as from IDLE (back-to-back allowed). DONE and start=0 -> IDLE.
- start while busy=1 is ignored with no side effects. The bin value of an ignored start is not captured.
- Latency: start sampled at edge 0 -> bcd/overflow updated and done high after edge BIN_W, low again after edge BIN_W+1. Throughput is one conversion per BIN_W+1 cycles.
- Overflow result: bcd = operand mod 10^DIGITS (top carries discarded), overflow=1.
- Output stability: bcd and overflow change only on the CONV->DONE edge or on reset, and hold between conversions.
- Arithmetic: add-3 is 4-bit with no inter-digit carry. The counter is $clog2(BIN_W)+1 bits wide, so BIN_W must be >=2.

Optional Feature:
- Macro: BIN2BCD_BLANK_EN.
- Defined:
  - Adds output blank [DIGITS-1:0]: bit i=1 iff digit i and all higher digits are zero.
  - blank[0] is forced to 0, so the units digit is never blanked.
  - Updated on the same edge as bcd. Reset value = {DIGITS-1{1'b1},1'b0}.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then start with bin=0 -> done exactly 32 edges after start; bcd=36'h000000000, overflow=0; busy high 32 cycles.
- bin=999999999 (32'h3B9AC9FF) -> bcd=36'h999999999, overflow=0. bin=12345 -> bcd=36'h000012345, and with BLANK_EN blank=9'b111100000.
- bin=1000000000 -> bcd=36'h000000000, overflow=1. bin=32'hFFFFFFFF -> bcd=36'h294967295, overflow=1. A following bin=7 clears overflow, bcd=36'h000000007.
- Start bin=42, then pulse start with bin=99 at cycle 10 of CONV -> second start ignored; single done, bcd=36'h000000042.
- Start asserted in the DONE cycle with bin=2023 after a conversion of 5 -> bcd=...005 held, then bcd=36'h000002023 exactly 33 edges after the first done.
- rst asserted at CONV cycle 15 -> next cycle busy=0, bcd=0, no done. A new start with bin=8 completes normally, bcd=36'h000000008.
